// File: rtl/chroma_subsample.sv
// 4:2:0 chroma decimator: passes Y through, folds four Cb/Cr quadrants
// into one 8x8 block of rounded 2x2 averages.
module chroma_subsample #(
    parameter int CH = 3,
    localparam int CW = $clog2(CH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_in,
    input  logic [CW-1:0]          ch_in,
    input  logic [7:0][7:0][7:0]   block_in,
    output logic [7:0][7:0][7:0]   block_out,
    output logic [CW-1:0]          ch_out,
    output logic                   valid_out,
    output logic                   err_out
);

    typedef logic [7:0][7:0][7:0] blk_t;
    typedef logic [3:0][3:0][7:0] qtr_t;
    typedef enum logic {IDLE, ACC} state_t;

    state_t        state, state_d;
    logic [1:0]    q, q_d;
    logic [CW-1:0] grp_ch, grp_d;
    blk_t          acc, acc_d;

    logic          valid_d, err_d;
    blk_t          blk_d;
    logic [CW-1:0] ch_d;

    logic       y_acc, c_acc, bad;
    logic       in_acc, match, mismatch, last;
    logic [1:0] wq;
    qtr_t       dec;

    function automatic qtr_t decim(input blk_t b);
        logic [9:0] s;
        decim = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 10'(b[2*i][2*j]) + 10'(b[2*i][2*j+1])
                  + 10'(b[2*i+1][2*j]) + 10'(b[2*i+1][2*j+1])
                  + 10'd2;
                decim[i][j] = s[9:2];
            end
        end
    endfunction

    assign y_acc    = valid_in && (ch_in == '0);
    assign bad      = valid_in && (ch_in >= CW'(CH));
    assign c_acc    = valid_in && !y_acc && !bad;
    assign in_acc   = (state == ACC);
    assign match    = (ch_in == grp_ch);
    assign mismatch = c_acc && in_acc && !match;
    // A mismatched chroma block restarts the group as its quadrant 0
    assign wq       = (in_acc && match) ? q : 2'd0;
    assign last     = c_acc && in_acc && match && (q == 2'd3);
    assign dec      = decim(block_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            q      <= '0;
            grp_ch <= '0;
        end else begin
            state  <= state_d;
            q      <= q_d;
            grp_ch <= grp_d;
        end
    end

    always_comb begin
        state_d = state;
        q_d     = q;
        grp_d   = grp_ch;
        unique case (1'b1)
            y_acc: begin
                state_d = IDLE;
                q_d     = '0;
            end
            c_acc: begin
                grp_d = ch_in;
                if (last) begin
                    state_d = IDLE;
                    q_d     = '0;
                end else begin
                    state_d = ACC;
                    q_d     = wq + 2'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        acc_d   = acc;
        valid_d = y_acc || last;
        err_d   = bad || mismatch || (y_acc && in_acc);
        blk_d   = block_out;
        ch_d    = ch_out;
        if (c_acc) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    if ((r / 4) == int'(wq[1]) && (c / 4) == int'(wq[0]))
                        acc_d[r][c] = dec[r % 4][c % 4];
                end
            end
        end
        unique case (1'b1)
            y_acc: begin
                blk_d = block_in;
                ch_d  = '0;
            end
            last: begin
                blk_d = acc_d;
                ch_d  = grp_ch;
            end
            default: ;
        endcase
    end

    // Buffer contents outside the current group are never emitted
    always_ff @(posedge clk) begin
        acc <= acc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            block_out <= '0;
            ch_out    <= '0;
            valid_out <= 1'b0;
            err_out   <= 1'b0;
        end else begin
            block_out <= blk_d;
            ch_out    <= ch_d;
            valid_out <= valid_d;
            err_out   <= err_d;
        end
    end

endmodule

// File: tb/tb_chroma_subsample.sv
// Bench for chroma_subsample: vector table, directed corner cases and
// random traffic against an MCU-image reference model.
module tb_chroma_subsample;

    typedef logic [7:0][7:0][7:0] blk_t;

    typedef struct {
        logic            v;
        logic [1:0]      ch;
        logic [7:0]      f;
        logic            ev;
        logic            ee;
        logic [1:0]      ech;
        logic [3:0][7:0] eq;
    } vec_t;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       valid_in = 0;
    logic [1:0] ch_in = 0;
    blk_t       block_in = '0;
    blk_t       block_out;
    logic [1:0] ch_out;
    logic       valid_out, err_out;

    int checks = 0;
    int errors = 0;

    int   m_grp, m_cnt;
    int   img [16][16];
    blk_t m_blk;
    logic [1:0] m_ch;
    logic m_v, m_e;

    vec_t tbl[$];

    logic [7:0] pv [3][4] = '{'{8'd1, 8'd1, 8'd1, 8'd2},
                              '{8'd1, 8'd2, 8'd2, 8'd2},
                              '{8'd255, 8'd255, 8'd255, 8'd255}};
    logic [7:0] pe [3] = '{8'd1, 8'd2, 8'd255};

    chroma_subsample #(.CH(3)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ch_in(ch_in),
        .block_in(block_in), .block_out(block_out), .ch_out(ch_out),
        .valid_out(valid_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic blk_t fill(input logic [7:0] v);
        blk_t b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) b[r][c] = v;
        return b;
    endfunction

    function automatic blk_t quads(input logic [3:0][7:0] eq);
        blk_t b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) b[r][c] = eq[(r / 4) * 2 + (c / 4)];
        return b;
    endfunction

    function automatic vec_t mk(input logic v, input logic [1:0] ch,
                                input logic [7:0] f, input logic ev,
                                input logic ee, input logic [1:0] ech,
                                input logic [3:0][7:0] eq);
        vec_t t;
        t.v = v; t.ch = ch; t.f = f;
        t.ev = ev; t.ee = ee; t.ech = ech; t.eq = eq;
        return t;
    endfunction

    task automatic m_reset();
        m_cnt = 0; m_grp = 0;
        m_blk = '0; m_ch = 0; m_v = 0; m_e = 0;
    endtask

    // Reference: paste quadrants into a 16x16 image, average when full
    task automatic m_step(input logic v, input logic [1:0] c, input blk_t b);
        int s;
        m_v = 0; m_e = 0;
        if (!v) return;
        if (c == 3) begin
            m_e = 1;
        end else if (c == 0) begin
            if (m_cnt > 0) m_e = 1;
            m_cnt = 0; m_v = 1; m_blk = b; m_ch = 0;
        end else begin
            if (m_cnt > 0 && int'(c) != m_grp) begin
                m_e = 1; m_cnt = 0;
            end
            if (m_cnt == 0) m_grp = int'(c);
            for (int r = 0; r < 8; r++)
                for (int k = 0; k < 8; k++)
                    img[8 * (m_cnt / 2) + r][8 * (m_cnt % 2) + k] = int'(b[r][k]);
            m_cnt++;
            if (m_cnt == 4) begin
                for (int r = 0; r < 8; r++)
                    for (int k = 0; k < 8; k++) begin
                        s = img[2*r][2*k] + img[2*r][2*k+1]
                          + img[2*r+1][2*k] + img[2*r+1][2*k+1] + 2;
                        m_blk[r][k] = 8'(s / 4);
                    end
                m_ch = c; m_v = 1; m_cnt = 0;
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [1:0] c, input blk_t b);
        valid_in = v; ch_in = c; block_in = b;
        @(posedge clk);
        #1;
        m_step(v, c, b);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        blk_t b, eb;
        int   cur, r1, r2;
        logic rv;
        logic [1:0] rc;

        m_reset();
        #2;
        chk("rst_blk", block_out, '0);
        chk("rst_ch", ch_out, 2'd0);
        chk("rst_v", valid_out, 1'b0);
        chk("rst_e", err_out, 1'b0);
        release_rst();

        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) b[r][c] = 8'(r * 8 + c);
        cyc(1, 0, b);
        chk("y_v", valid_out, 1'b1);
        chk("y_ch", ch_out, 2'd0);
        chk("y_e", err_out, 1'b0);
        chk("y_blk", block_out, b);
        cyc(0, 0, '0);
        chk("y_pulse", valid_out, 1'b0);
        chk("y_hold", block_out, b);

        eb = '0;
        for (int qq = 0; qq < 4; qq++) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    int k;
                    k = (i + j + qq) % 3;
                    b[2*i][2*j]     = pv[k][0];
                    b[2*i][2*j+1]   = pv[k][1];
                    b[2*i+1][2*j]   = pv[k][2];
                    b[2*i+1][2*j+1] = pv[k][3];
                    eb[4*(qq/2)+i][4*(qq%2)+j] = pe[k];
                end
            cyc(1, 2, b);
            chk($sformatf("rnd_v%0d", qq), valid_out, qq == 3);
            if (qq < 3) begin
                cyc(0, 0, '0);
                cyc(0, 0, '0);
                chk("rnd_gap", valid_out, 1'b0);
            end
        end
        chk("rnd_ch", ch_out, 2'd2);
        chk("rnd_blk", block_out, eb);

        cyc(1, 2, fill(8'd11));
        cyc(1, 2, fill(8'd12));
        rst_n = 0;
        #1;
        m_reset();
        chk("mrst_blk", block_out, '0);
        chk("mrst_ch", ch_out, 2'd0);
        chk("mrst_v", valid_out, 1'b0);
        release_rst();
        for (int qq = 0; qq < 4; qq++) cyc(1, 2, fill(8'(qq * 3 + 7)));
        chk("post_v", valid_out, 1'b1);
        chk("post_ch", ch_out, 2'd2);
        chk("post_blk", block_out, quads({8'd16, 8'd13, 8'd10, 8'd7}));
        cyc(1, 3, fill(8'd9));
        chk("ill_e", err_out, 1'b1);
        chk("ill_v", valid_out, 1'b0);
        chk("ill_hold", block_out, quads({8'd16, 8'd13, 8'd10, 8'd7}));

        tbl.push_back(mk(1, 1, 10, 0, 0, 0, '0));
        tbl.push_back(mk(1, 1, 20, 0, 0, 0, '0));
        tbl.push_back(mk(1, 1, 30, 0, 0, 0, '0));
        tbl.push_back(mk(1, 1, 40, 1, 0, 1, {8'd40, 8'd30, 8'd20, 8'd10}));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(1, 1, 5, 0, 0, 0, '0));
        tbl.push_back(mk(1, 1, 6, 0, 0, 0, '0));
        tbl.push_back(mk(1, 0, 77, 1, 1, 0, {4{8'd77}}));
        tbl.push_back(mk(1, 2, 1, 0, 0, 0, '0));
        tbl.push_back(mk(1, 2, 2, 0, 0, 0, '0));
        tbl.push_back(mk(1, 2, 3, 0, 0, 0, '0));
        tbl.push_back(mk(1, 2, 4, 1, 0, 2, {8'd4, 8'd3, 8'd2, 8'd1}));
        tbl.push_back(mk(1, 1, 9, 0, 0, 0, '0));
        tbl.push_back(mk(1, 1, 9, 0, 0, 0, '0));
        tbl.push_back(mk(1, 2, 50, 0, 1, 0, '0));
        tbl.push_back(mk(1, 2, 60, 0, 0, 0, '0));
        tbl.push_back(mk(1, 2, 70, 0, 0, 0, '0));
        tbl.push_back(mk(1, 2, 80, 1, 0, 2, {8'd80, 8'd70, 8'd60, 8'd50}));
        tbl.push_back(mk(1, 3, 0, 0, 1, 0, '0));
        tbl.push_back(mk(1, 1, 100, 0, 0, 0, '0));
        tbl.push_back(mk(1, 1, 101, 0, 0, 0, '0));
        tbl.push_back(mk(1, 1, 102, 0, 0, 0, '0));
        tbl.push_back(mk(1, 1, 103, 1, 0, 1, {8'd103, 8'd102, 8'd101, 8'd100}));
        tbl.push_back(mk(1, 2, 200, 0, 0, 0, '0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, '0));

        for (int k = 0; k < tbl.size(); k++) begin
            cyc(tbl[k].v, tbl[k].ch, fill(tbl[k].f));
            chk($sformatf("t%0d_v", k), valid_out, tbl[k].ev);
            chk($sformatf("t%0d_e", k), err_out, tbl[k].ee);
            if (tbl[k].ev) begin
                chk($sformatf("t%0d_ch", k), ch_out, tbl[k].ech);
                chk($sformatf("t%0d_blk", k), block_out, quads(tbl[k].eq));
            end
        end

        rst_n = 0;
        #1;
        m_reset();
        release_rst();
        cur = 1;
        for (int n = 0; n < 800; n++) begin
            r1 = $urandom_range(0, 99);
            r2 = $urandom_range(0, 99);
            rv = (r1 >= 20);
            if (r2 < 8) rc = 2'd0;
            else if (r2 < 12) rc = 2'd3;
            else begin
                if (r2 < 18) cur = 3 - cur;
                rc = 2'(cur);
            end
            for (int r = 0; r < 8; r++) b[r] = {$urandom(), $urandom()};
            cyc(rv, rc, b);
            chk($sformatf("r%0d_v", n), valid_out, m_v);
            chk($sformatf("r%0d_e", n), err_out, m_e);
            chk($sformatf("r%0d_ch", n), ch_out, m_ch);
            chk($sformatf("r%0d_blk", n), block_out, m_blk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chroma_subsample.md
# chroma_subsample

Encoder-side 4:2:0 chroma decimator for the JPEG pipeline, the inverse of the decoder's chroma upsampler. Luma (Y) blocks pass through with one cycle of latency. Four consecutive full-resolution 8x8 Cb (or Cr) blocks covering one 16x16 MCU region are collected. The block then emits one 8x8 chroma block built from rounded 2x2 averages, ahead of the forward DCT.

## Interface
- `CH`, default 3: number of colour channels. Sets the channel-tag width `$clog2(CH+1)` (2 bits at default).
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `valid_in`  in  1: `block_in`/`ch_in` valid this cycle. One block per cycle max; no backpressure.
- `ch_in`  in  `$clog2(CH+1)`: channel tag. 0=Y, 1=Cb, 2=Cr, 3=illegal.
- `block_in`  in  8x[7:0][7:0]: 8x8 unsigned samples, `[row][col]`.
- `block_out`  out  8x[7:0][7:0]: output block. Holds its value between outputs.
- `ch_out`  out  `$clog2(CH+1)`: channel tag of `block_out`.
- `valid_out`  out  1: single-cycle pulse when `block_out` is new.
- `err_out`  out  1: single-cycle pulse on protocol violation.

## Operation
- Chroma quadrant order within a group: q=0 top-left, 1 top-right, 2 bottom-left, 3 bottom-right.
- State:
  - 2-bit quadrant counter `q`.
  - Group channel register `grp_ch`.
  - 8x8x8 accumulation buffer `acc`.
  - FSM with states IDLE (q=0) and ACC (q in 1..3).
- Decimation of quadrant `q` (qr=q[1], qc=q[0]), for i,j in 0..3:
  - `acc[4*qr+i][4*qc+j] = (b[2i][2j] + b[2i][2j+1] + b[2i+1][2j] + b[2i+1][2j+1] + 2) >> 2`.
  - Sum is 10 bits wide; the result is 0..255 and never saturates.
- Y accepted (`valid_in`, `ch_in`=0):
  - Next cycle: `block_out`=`block_in`, `ch_out`=0, `valid_out`=1.
  - If in ACC: the partial group is discarded, FSM goes to IDLE, and `err_out`=1 in the same cycle as `valid_out`.
- Chroma accepted in IDLE: writes quadrant 0, `grp_ch`<=`ch_in`, goes to ACC with q=1.
- Chroma accepted in ACC with `ch_in`==`grp_ch`: writes quadrant q, q<=q+1.
  - When q==3, the group completes. Next cycle `block_out` = the three buffered quadrants plus the quadrant-3 averages computed from the current input, `ch_out`=`grp_ch`, `valid_out`=1. FSM returns to IDLE, q wraps to 0.
- Chroma accepted in ACC with `ch_in`!=`grp_ch`:
  - Old partial group dropped and `err_out`=1.
  - The input is treated as quadrant 0 of a new group for `ch_in`; q=1.
- `ch_in`=3 with `valid_in`: `err_out`=1. State and outputs otherwise unchanged, no `valid_out`.
- `valid_in`=0: no state change. `valid_out`/`err_out` deassert.
- Regions of `acc` not yet written in the current group are don't-care. They are never emitted because output occurs only at q==3.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - `block_out` all 0, `ch_out`=0, `valid_out`=0, `err_out`=0.
  - q=0, FSM IDLE, `grp_ch`=0. Contents of `acc` are don't-care.
- Y latency: 1 cycle, accept edge to `valid_out`.
- Chroma latency: 1 cycle after the 4th quadrant is accepted. Minimum group duration is 4 cycles; gaps between quadrants are allowed and unbounded.
- Back-to-back: Cb q3 followed immediately by Cr q0 (or Y) is legal. `valid_out` for Cb occurs in the same cycle the next block is accepted.
- Reset mid-group: all progress lost. The first chroma block after release is quadrant 0.
- `valid_out` and `err_out` are each asserted for exactly one cycle per triggering input. `block_out`/`ch_out` are stable until the next `valid_out`.

## Test plan
- Reset, then Y block with `block_in[r][c]`=r*8+c -> one cycle later `valid_out`=1, `ch_out`=0, `block_out` identical, `err_out`=0.
- Cb quadrants constant 10, 20, 30, 40 on consecutive cycles -> single `valid_out` with `ch_out`=1. `block_out` rows 0-3: cols 0-3 =10, cols 4-7 =20. Rows 4-7: cols 0-3 =30, cols 4-7 =40.
- Rounding: a 2x2 of {1,1,1,2} -> 1, {1,2,2,2} -> 2, {255,255,255,255} -> 255. Checked at every output position across a full Cr group with idle gaps between quadrants.
- Two Cb quadrants then a Y block -> Y emitted with `err_out`=1. A following four-block Cr group emits normally with `ch_out`=2.
- Cb q0, Cb q1, then Cr -> `err_out`=1. Three more Cr blocks complete a Cr output, and no Cb output appears.
- Assert `rst_n` low after two Cr quadrants -> all outputs 0 immediately. Four new Cr blocks after release -> correct output. `ch_in`=3 input -> `err_out` pulse only, no `valid_out`.
